// File: rtl/pipe_flow_ctrl_pkg.sv
// pipe_flow_ctrl_pkg: FSM state encoding and pipeline control output bundles
//   state_e : RUN / STALL / FLUSH
//   ctrl_t  : {pc_write, pc_sel, ifid_write, ifid_flush, idex_bubble}
package pipe_flow_ctrl_pkg;
    typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2} state_e;
    typedef struct packed {
        logic pc_write;
        logic pc_sel;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
    } ctrl_t;
    localparam ctrl_t CTRL_RESET    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam ctrl_t CTRL_IDLE     = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam ctrl_t CTRL_FREEZE   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam ctrl_t CTRL_REDIRECT = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam ctrl_t CTRL_BUBBLE   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
endpackage

// File: rtl/pipe_flow_ctrl_if.sv
// pipe_flow_ctrl_if: hazard-controller requests in, pipeline enables/flushes/redirect out
//   master : hazard controller side (drives PCStall, MP, RedirectPC)
//   slave  : pipe_flow_ctrl side (drives enables, NextPC, StallTimeout, perf counters)
interface pipe_flow_ctrl_if #(parameter int PC_W = 16);
    logic            PCStall;
    logic            MP;
    logic [PC_W-1:0] RedirectPC;
    logic            PCWrite;
    logic            PCSel;
    logic [PC_W-1:0] NextPC;
    logic            IFIDWrite;
    logic            IFIDFlush;
    logic            IDEXBubble;
    logic            StallTimeout;
    logic [15:0]     StallCount;
    logic [15:0]     FlushCount;
    modport master (
        output PCStall, MP, RedirectPC,
        input  PCWrite, PCSel, NextPC, IFIDWrite, IFIDFlush, IDEXBubble,
               StallTimeout, StallCount, FlushCount
    );
    modport slave (
        input  PCStall, MP, RedirectPC,
        output PCWrite, PCSel, NextPC, IFIDWrite, IFIDFlush, IDEXBubble,
               StallTimeout, StallCount, FlushCount
    );
endinterface

// File: rtl/pipe_flow_ctrl_sat_counter.sv
// sat_counter: W-bit counter with synchronous clear and enable, saturating at all-ones
//   clk_i clock, clr_i sync clear (wins over en_i), en_i increment enable, cnt_o count
module sat_counter #(parameter int W = 16) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q;
    always_ff @(posedge clk_i) begin
        if (clr_i) cnt_q <= '0;
        else if (en_i && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end
    assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_flow_ctrl.sv
// pipe_flow_ctrl: turns stall/mispredict requests into freeze, bubble, flush and PC redirect controls
//   clock, reset (sync, active-high); bus: pipe_flow_ctrl_if.slave
//   Outputs are a Mealy decode of state and requests; NextPC and StallTimeout are registered.
//   PIPE_PERF_EN: when defined, StallCount/FlushCount are saturating counters; otherwise tied to 0.
module pipe_flow_ctrl
    import pipe_flow_ctrl_pkg::*;
#(
    parameter int PC_W        = 16,
    parameter int FLUSH_DEPTH = 2,
    parameter int STALL_MAX   = 15
) (
    input logic             clock,
    input logic             reset,
    pipe_flow_ctrl_if.slave bus
);
    localparam int SCW = $clog2(STALL_MAX + 1);
    localparam logic [SCW-1:0] SMAX = SCW'(STALL_MAX);
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_DEPTH - 1);
    state_e          state_q;
    logic [SCW-1:0]  stall_cnt_q;
    logic [2:0]      flush_cnt_q;
    logic [PC_W-1:0] next_pc_q;
    logic            timeout_q;
    logic            wd_release;
    ctrl_t           ctrl;
    // Watchdog: a stall that has already frozen STALL_MAX cycles is let through for one cycle.
    assign wd_release = state_q == STALL && stall_cnt_q == SMAX && bus.PCStall;
    // FLUSH is tested before PCStall so stalls are ignored while bubbles drain.
    always_comb begin
        ctrl = reset ? CTRL_RESET :
               bus.MP ? CTRL_REDIRECT :
               state_q == FLUSH ? CTRL_BUBBLE :
               (bus.PCStall && !wd_release) ? CTRL_FREEZE : CTRL_IDLE;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            next_pc_q   <= '0;
            timeout_q   <= 1'b0;
        end else if (bus.MP) begin
            next_pc_q   <= bus.RedirectPC;
            flush_cnt_q <= FLUSH_LOAD;
            stall_cnt_q <= '0;
            state_q     <= (FLUSH_DEPTH == 1) ? RUN : FLUSH;
        end else if (state_q == FLUSH) begin
            flush_cnt_q <= flush_cnt_q - 3'd1;
            state_q     <= (flush_cnt_q == 3'd1) ? RUN : FLUSH;
        end else if (wd_release) begin
            timeout_q   <= 1'b1;
            stall_cnt_q <= '0;
            state_q     <= RUN;
        end else if (bus.PCStall) begin
            stall_cnt_q <= (state_q == STALL) ? stall_cnt_q + SCW'(1) : SCW'(1);
            state_q     <= STALL;
        end else begin
            stall_cnt_q <= '0;
            state_q     <= RUN;
        end
    end
    assign bus.PCWrite      = ctrl.pc_write;
    assign bus.PCSel        = ctrl.pc_sel;
    assign bus.IFIDWrite    = ctrl.ifid_write;
    assign bus.IFIDFlush    = ctrl.ifid_flush;
    assign bus.IDEXBubble   = ctrl.idex_bubble;
    assign bus.NextPC       = next_pc_q;
    assign bus.StallTimeout = timeout_q;
`ifdef PIPE_PERF_EN
    sat_counter #(.W(16)) u_stall_count (
        .clk_i(clock),
        .clr_i(reset),
        .en_i (!ctrl.pc_write),
        .cnt_o(bus.StallCount)
    );
    sat_counter #(.W(16)) u_flush_count (
        .clk_i(clock),
        .clr_i(reset),
        .en_i (bus.MP),
        .cnt_o(bus.FlushCount)
    );
`else
    assign bus.StallCount = '0;
    assign bus.FlushCount = '0;
`endif
endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// tb_pipe_flow_ctrl: directed scenarios plus random stimulus checked every cycle against a behavioural model
module tb_pipe_flow_ctrl;
    localparam int FLUSH_DEPTH = 2;
    localparam int STALL_MAX   = 15;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    pipe_flow_ctrl_if #(.PC_W(16)) bus ();
    pipe_flow_ctrl #(.PC_W(16), .FLUSH_DEPTH(FLUSH_DEPTH), .STALL_MAX(STALL_MAX)) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus)
    );
    always #5 clk = ~clk;
    // Model: bubbles still owed after a redirect, length of the current frozen run,
    // sticky timeout, last redirect target and the two performance counts.
    logic        m_valid = 1'b0;
    int          m_bubbles;
    int          m_frozen;
    logic        m_timeout;
    logic [15:0] m_next_pc;
    logic [15:0] m_sc;
    logic [15:0] m_fc;
    logic [4:0]  exp_now;
    logic [4:0]  act_now;
    // {PCWrite, PCSel, IFIDWrite, IFIDFlush, IDEXBubble}
    assign exp_now = rst ? 5'b00011 :
                     bus.MP ? 5'b11111 :
                     (m_bubbles != 0) ? 5'b10101 :
                     bus.PCStall ? ((m_frozen == STALL_MAX) ? 5'b10100 : 5'b00001) :
                     5'b10100;
    assign act_now = {bus.PCWrite, bus.PCSel, bus.IFIDWrite, bus.IFIDFlush, bus.IDEXBubble};
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    always @(posedge clk) begin
        if (rst) begin
            m_valid   <= 1'b1;
            m_bubbles <= 0;
            m_frozen  <= 0;
            m_timeout <= 1'b0;
            m_next_pc <= '0;
            m_sc      <= '0;
            m_fc      <= '0;
        end else if (m_valid) begin
            if (!exp_now[4] && m_sc != 16'hFFFF) m_sc <= m_sc + 16'd1;
            if (bus.MP) begin
                if (m_fc != 16'hFFFF) m_fc <= m_fc + 16'd1;
                m_bubbles <= FLUSH_DEPTH - 1;
                m_next_pc <= bus.RedirectPC;
                m_frozen  <= 0;
            end else if (m_bubbles != 0) begin
                m_bubbles <= m_bubbles - 1;
            end else if (bus.PCStall) begin
                if (m_frozen == STALL_MAX) begin
                    m_frozen  <= 0;
                    m_timeout <= 1'b1;
                end else begin
                    m_frozen <= m_frozen + 1;
                end
            end else begin
                m_frozen <= 0;
            end
        end
    end
    always @(negedge clk) begin
        if (m_valid) begin
            check("ctrl", 32'(act_now), 32'(exp_now));
            check("timeout", 32'(bus.StallTimeout), 32'(m_timeout));
            check("nextpc", 32'(bus.NextPC), 32'(m_next_pc));
`ifdef PIPE_PERF_EN
            check("stallcount", 32'(bus.StallCount), 32'(m_sc));
            check("flushcount", 32'(bus.FlushCount), 32'(m_fc));
`else
            check("stallcount_off", 32'(bus.StallCount), 32'd0);
            check("flushcount_off", 32'(bus.FlushCount), 32'd0);
`endif
        end
    end
    task automatic set_in(input logic r, input logic s, input logic m, input logic [15:0] p);
        rst = r;
        bus.PCStall = s;
        bus.MP = m;
        bus.RedirectPC = p;
        #2;
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    initial begin
        logic hold;
        bus.PCStall = 1'b0;
        bus.MP = 1'b0;
        bus.RedirectPC = '0;
        hold = 1'b0;
        set_in(1, 0, 0, 16'h0);
        tick();
        set_in(1, 0, 0, 16'h0);
        check("rst_pcwrite", 32'(bus.PCWrite), 32'd0);
        check("rst_ifidflush", 32'(bus.IFIDFlush), 32'd1);
        check("rst_bubble", 32'(bus.IDEXBubble), 32'd1);
        check("rst_timeout", 32'(bus.StallTimeout), 32'd0);
        tick();
        set_in(0, 0, 0, 16'h0);
        check("post_rst_ctrl", 32'(act_now), 32'b10100);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(0, 1, 0, 16'h0);
            check("stall3_pcwrite", 32'(bus.PCWrite), 32'd0);
            check("stall3_ifidwrite", 32'(bus.IFIDWrite), 32'd0);
            check("stall3_bubble", 32'(bus.IDEXBubble), 32'd1);
            tick();
        end
        set_in(0, 0, 0, 16'h0);
        check("stall3_release", 32'(act_now), 32'b10100);
        tick();
`ifdef PIPE_PERF_EN
        check("stall3_count", 32'(bus.StallCount), 32'd3);
`endif
        set_in(0, 0, 1, 16'h0040);
        check("mp_pcsel", 32'(bus.PCSel), 32'd1);
        check("mp_ifidflush", 32'(bus.IFIDFlush), 32'd1);
        tick();
        check("mp_nextpc", 32'(bus.NextPC), 32'h0040);
        set_in(0, 0, 0, 16'h0);
        check("flush1_ctrl", 32'(act_now), 32'b10101);
        tick();
        set_in(0, 0, 0, 16'h0);
        check("flush_done_ctrl", 32'(act_now), 32'b10100);
        tick();
        set_in(0, 1, 1, 16'h1234);
        check("mp_stall_ctrl", 32'(act_now), 32'b11111);
        tick();
`ifdef PIPE_PERF_EN
        check("mp_stall_flushcount", 32'(bus.FlushCount), 32'd2);
`endif
        set_in(0, 0, 0, 16'h0);
        tick();
        tick();
        for (int i = 1; i <= 20; i++) begin
            set_in(0, 1, 0, 16'h0);
            check("wd_pcwrite", 32'(bus.PCWrite), 32'(i == 16));
            tick();
            if (i == 16) check("wd_timeout", 32'(bus.StallTimeout), 32'd1);
        end
        check("wd_sticky", 32'(bus.StallTimeout), 32'd1);
        set_in(0, 0, 0, 16'h0);
        tick();
        set_in(0, 0, 1, 16'h0080);
        tick();
        set_in(1, 0, 0, 16'h0);
        check("rst_in_flush", 32'(act_now), 32'b00011);
        tick();
        set_in(0, 0, 0, 16'h0);
        check("after_rst_ctrl", 32'(act_now), 32'b10100);
        check("after_rst_timeout", 32'(bus.StallTimeout), 32'd0);
        check("after_rst_nextpc", 32'(bus.NextPC), 32'd0);
        tick();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) hold = !hold;
            set_in($urandom_range(0, 199) == 0,
                   hold ? 1'b1 : ($urandom_range(0, 3) == 0),
                   $urandom_range(0, 11) == 0,
                   16'($urandom));
            tick();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
